// File: rtl/adc_regbank_pkg.sv
// Shared register map, CTRL/STATUS bit positions and conversion FSM states
// for the APB3 ADC register bank.
package adc_regbank_pkg;

   localparam logic [11:0] ADDR_CTRL   = 12'h100;
   localparam logic [11:0] ADDR_STATUS = 12'h104;
   localparam logic [11:0] ADDR_PERIOD = 12'h108;

   localparam int unsigned CTRL_START  = 0;
   localparam int unsigned CTRL_CONT   = 1;
   localparam int unsigned CTRL_IRQ_EN = 2;

   localparam int unsigned ST_BUSY     = 0;
   localparam int unsigned ST_DVALID   = 1;
   localparam int unsigned ST_OVERRUN  = 2;
   localparam int unsigned ST_TIMEOUT  = 3;

   typedef enum logic [1:0] {
      CONV_IDLE = 2'd0,
      CONV_FIRE = 2'd1,
      CONV_WAIT = 2'd2
   } conv_state_e;

endpackage

// File: rtl/adc_conv_ctrl.sv
// Conversion sequencer: IDLE -> FIRE -> WAIT FSM, free-running period counter
// for continuous mode, and the WAIT-state timeout counter.
module adc_conv_ctrl
   import adc_regbank_pkg::*;
#(
   parameter int unsigned TMO_CYC = 4096
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        cpu_start,
   input  logic        cont,
   input  logic [31:0] period,
   input  logic        sample_valid,
   output logic        start,
   output logic        busy,
   output logic        capture,
   output logic        timeout,
   output logic        overrun
);

   conv_state_e state_q, state_d;
   logic [31:0] per_cnt_q;
   logic [31:0] tmo_cnt_q;
   logic        per_req;
   logic        req;

   // CPU start and period expiry in the same cycle merge into a single request
   always_comb begin
      per_req = cont && (period != '0) && (per_cnt_q >= period - 32'd1);
      req     = cpu_start | per_req;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || !cont || period == '0 || per_req) per_cnt_q <= '0;
      else                                            per_cnt_q <= per_cnt_q + 32'd1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || state_q != CONV_WAIT) tmo_cnt_q <= '0;
      else                               tmo_cnt_q <= tmo_cnt_q + 32'd1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= CONV_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      start   = 1'b0;
      capture = 1'b0;
      timeout = 1'b0;
      overrun = 1'b0;
      case (state_q)
         CONV_IDLE: if (req) state_d = CONV_FIRE;
         CONV_FIRE: begin
            start   = 1'b1;
            overrun = req;
            state_d = CONV_WAIT;
         end
         CONV_WAIT: begin
            overrun = req;
            if (sample_valid) begin
               capture = 1'b1;
               state_d = CONV_IDLE;
            end else if (tmo_cnt_q == 32'(TMO_CYC - 1)) begin
               timeout = 1'b1;
               state_d = CONV_IDLE;
            end
         end
         default: state_d = CONV_IDLE;
      endcase
   end

   always_comb busy = (state_q != CONV_IDLE);

endmodule

// File: rtl/apb3_adc_regbank.sv
// APB3 register bank for a multi-channel ADC: decode, CH/CTRL/STATUS/PERIOD
// registers and sample capture. Define ADC_IRQ_EN to enable the interrupt output.
module apb3_adc_regbank
   import adc_regbank_pkg::*;
#(
   parameter int unsigned NUM_CH  = 8,
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned TMO_CYC = 4096
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [11:0]              PADDR,
   input  logic                     PSEL,
   input  logic                     PENABLE,
   input  logic                     PWRITE,
   input  logic [31:0]              PWDATA,
   output logic [31:0]              PRDATA,
   output logic                     PREADY,
   output logic                     PSLVERR,
   input  logic [NUM_CH*DATA_W-1:0] samples_i,
   input  logic                     sample_valid_i,
   output logic                     start_o,
   output logic                     irq_o
);

   logic [DATA_W-1:0] ch_q [NUM_CH];
   logic        cont_q, irq_en_q;
   logic        dvalid_q, overrun_q, timeout_q;
   logic [31:0] period_q, prdata_q;
   logic        slverr_q;

   logic        setup, access, wr_en, cpu_start;
   logic        ch_win, ch_ok, is_ctrl, is_status, is_period, err;
   logic [31:0] ch_rd, ctrl_rd, status_rd, rd_data;
   logic        busy, capture, timeout, conv_ovr;

   always_comb begin
      setup     = PSEL & ~PENABLE;
      access    = PSEL & PENABLE;
      ch_win    = (PADDR[11:8] == 4'h0) && (PADDR[1:0] == 2'b00);
      is_ctrl   = (PADDR == ADDR_CTRL);
      is_status = (PADDR == ADDR_STATUS);
      is_period = (PADDR == ADDR_PERIOD);
      ch_ok     = 1'b0;
      ch_rd     = '0;
      for (int unsigned n = 0; n < NUM_CH; n++) begin
         if (PADDR[7:2] == 6'(n)) begin
            ch_ok = ch_win;
            ch_rd = 32'(signed'(ch_q[n]));
         end
      end
      err       = !(ch_ok | is_ctrl | is_status | is_period) | (PWRITE & ch_ok);
      wr_en     = access & PWRITE & ~err;
      cpu_start = wr_en & is_ctrl & PWDATA[CTRL_START];

      ctrl_rd                = '0;
      ctrl_rd[CTRL_CONT]     = cont_q;
      ctrl_rd[CTRL_IRQ_EN]   = irq_en_q;
      status_rd              = '0;
      status_rd[ST_BUSY]     = busy;
      status_rd[ST_DVALID]   = dvalid_q;
      status_rd[ST_OVERRUN]  = overrun_q;
      status_rd[ST_TIMEOUT]  = timeout_q;

      rd_data = '0;
      if (ch_ok)          rd_data = ch_rd;
      else if (is_ctrl)   rd_data = ctrl_rd;
      else if (is_status) rd_data = status_rd;
      else if (is_period) rd_data = period_q;
   end

   // Read data and error are captured in setup so both are stable for the access phase
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         prdata_q <= '0;
         slverr_q <= 1'b0;
      end else if (setup) begin
         slverr_q <= err;
         if (!PWRITE) prdata_q <= err ? '0 : rd_data;
      end
   end

   always_comb begin
      PRDATA  = prdata_q;
      PREADY  = 1'b1;
      PSLVERR = slverr_q & access;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cont_q   <= 1'b0;
         period_q <= '0;
      end else if (wr_en) begin
         if (is_ctrl)   cont_q   <= PWDATA[CTRL_CONT];
         if (is_period) period_q <= PWDATA;
      end
   end

`ifdef ADC_IRQ_EN
   logic irq_q;
   always_ff @(posedge clk_i) begin
      if (rst_i)                 irq_en_q <= 1'b0;
      else if (wr_en && is_ctrl) irq_en_q <= PWDATA[CTRL_IRQ_EN];
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) irq_q <= 1'b0;
      else       irq_q <= irq_en_q & (dvalid_q | overrun_q | timeout_q);
   end
   always_comb irq_o = irq_q;
`else
   always_comb begin
      irq_en_q = 1'b0;
      irq_o    = 1'b0;
   end
`endif

   // Hardware sets are OR-ed in after the W1C mask, so they win a same-cycle clear
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         dvalid_q  <= 1'b0;
         overrun_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         dvalid_q  <= (dvalid_q  & ~(wr_en & is_status & PWDATA[ST_DVALID])) | capture;
         overrun_q <= (overrun_q & ~(wr_en & is_status & PWDATA[ST_OVERRUN]))
                      | conv_ovr | (capture & dvalid_q);
         timeout_q <= (timeout_q & ~(wr_en & is_status & PWDATA[ST_TIMEOUT])) | timeout;
      end
   end

   always_ff @(posedge clk_i) begin
      for (int unsigned n = 0; n < NUM_CH; n++) begin
         if (rst_i)        ch_q[n] <= '0;
         else if (capture) ch_q[n] <= samples_i[n*DATA_W +: DATA_W];
      end
   end

   adc_conv_ctrl #(
      .TMO_CYC (TMO_CYC)
   ) u_conv_ctrl (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .cpu_start    (cpu_start),
      .cont         (cont_q),
      .period       (period_q),
      .sample_valid (sample_valid_i),
      .start        (start_o),
      .busy         (busy),
      .capture      (capture),
      .timeout      (timeout),
      .overrun      (conv_ovr)
   );

endmodule

// File: doc/apb3_adc_regbank.md
APB3_ADC_REGBANK -- requirements
Module: apb3_adc_regbank

Interface
REQ-001 SHALL have parameter NUM_CH, default 8: number of ADC channels, 1..16.
REQ-002 SHALL have parameter DATA_W, default 16: sample width, 8..32.
REQ-003 SHALL have parameter TMO_CYC, default 4096: conversion timeout in clk_i cycles.
REQ-004 SHALL have port clk_i, input, 1: single clock for all logic.
REQ-005 SHALL have port rst_i, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have APB3 ports PADDR in 12, PSEL in 1, PENABLE in 1, PWRITE in 1, PWDATA in 32, PRDATA out 32, PREADY out 1, PSLVERR out 1.
REQ-007 SHALL have port samples_i, input, NUM_CH*DATA_W: channel n occupies bits [n*DATA_W +: DATA_W].
REQ-008 SHALL have port sample_valid_i, input, 1: one-cycle strobe, samples_i valid.
REQ-009 SHALL have port start_o, output, 1: one-cycle conversion start pulse.
REQ-010 SHALL have port irq_o, output, 1: level interrupt.

Function
REQ-011 SHALL map these registers: 0x000+4n CH[n] (RO, sign-extended to 32 bits); 0x100 CTRL (RW: bit0 START write-1 pulse reads 0, bit1 CONT, bit2 IRQ_EN); 0x104 STATUS (bit0 BUSY RO, bit1 DVALID W1C, bit2 OVERRUN W1C, bit3 TIMEOUT W1C); 0x108 PERIOD (RW, 32 bits).
REQ-012 SHALL drive PREADY=1 always (zero wait states).
REQ-013 SHALL register PRDATA in the setup phase (PSEL & !PENABLE & !PWRITE), valid throughout the access phase, and hold it otherwise.
REQ-014 SHALL commit writes on PSEL & PENABLE & PWRITE, taking effect the next cycle.
REQ-015 SHALL assert PSLVERR in the access phase for an unmapped address, for CH[n] with n>=NUM_CH, or for a write to a RO address; such writes have no effect.
REQ-016 SHALL use the FSM states IDLE -> FIRE (1 cycle, start_o=1) -> WAIT -> IDLE; BUSY=1 in FIRE and WAIT.
REQ-017 SHALL generate a start request from a write with CTRL.START=1, or from period-counter expiry when CONT=1.
REQ-018 SHALL run the period counter from 0 to PERIOD-1 and then wrap, issuing a request on wrap; PERIOD=0 disables it; clearing CONT resets the counter to 0.
REQ-019 SHALL take IDLE->FIRE on a request; a request while not IDLE is dropped and sets OVERRUN.
REQ-020 SHALL, in WAIT on sample_valid_i, latch all NUM_CH channels in the same cycle, set DVALID, and go to IDLE; if DVALID was already 1, it also sets OVERRUN.
REQ-021 SHALL leave CH registers unchanged on sample_valid_i outside WAIT.
REQ-022 SHALL leave WAIT after TMO_CYC cycles with no strobe: go to IDLE, set TIMEOUT, CH unchanged.
REQ-023 SHALL let a hardware set win over a W1C clear of the same bit in the same cycle.
REQ-024 SHALL let a CPU START request in the same cycle as a period expiry count as one request.

Reset
REQ-025 SHALL, when rst_i=1 at a clk_i edge, put the FSM in IDLE and set CH, CTRL, STATUS, PERIOD, the counters and PRDATA to 0, start_o=0, PSLVERR=0, irq_o=0.
REQ-026 SHALL, on reset mid-conversion, abandon the conversion; a late sample_valid_i is ignored.

Configuration
REQ-027 SHALL, with macro ADC_IRQ_EN defined, drive irq_o = CTRL.IRQ_EN & (DVALID | OVERRUN | TIMEOUT), registered.
REQ-028 SHALL, without ADC_IRQ_EN, tie irq_o to 0 and make CTRL.IRQ_EN read 0.

Structure
REQ-029 SHALL place register offsets, CTRL/STATUS bit positions and the FSM state enum in package adc_regbank_pkg.
REQ-030 SHALL implement the FSM, period counter and timeout counter in sub-module adc_conv_ctrl; the APB decode, register file and capture logic stay in the top module.

Verification
REQ-031 SHALL cover: write CTRL=0x1 -> start_o high exactly 1 cycle, 1 cycle after the access phase; strobe with ch0=0x8001 -> CH0 reads 0xFFFF8001, STATUS=0x2.
REQ-032 SHALL cover: PERIOD=100, CONT=1 -> start_o every 100 cycles, provided each conversion finishes within 100 cycles.
REQ-033 SHALL cover: second START during WAIT -> no extra start_o, OVERRUN=1; write STATUS=0x4 -> OVERRUN=0.
REQ-034 SHALL cover: no strobe after START -> BUSY drops after TMO_CYC cycles, STATUS=0x8, CH unchanged.
REQ-035 SHALL cover: read 0x200 -> PSLVERR=1; write CH0 -> PSLVERR=1, CH0 unchanged; W1C of DVALID in the same cycle as a strobe -> DVALID stays 1.
REQ-036 SHALL cover: with ADC_IRQ_EN, IRQ_EN=1 and a capture -> irq_o=1, cleared 2 cycles after the DVALID W1C; without the macro -> irq_o stays 0.
